// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
// The request struct is sized for the default 64-bit / 5-bit configuration.
package regfile_ctrl_pkg;

    localparam int WB_DATA_W   = 64;
    localparam int WB_ADDR_W   = 5;
    localparam int WB_MAX_WAIT = 4;
    localparam int WAIT_CNT_W  = $clog2(WB_MAX_WAIT + 1);

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on reservation, cleared on write-back grant.
// Register 0 is hard-wired not busy.
module reg_scoreboard #(
    parameter int REG_DEPTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd2_addr_i,
    input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
    output logic                  src_busy_o,
    output logic                  rsv_free_o,
    output logic [REG_DEPTH-1:0]  busy_mask_o
);

    logic [REG_DEPTH-1:0] busy_q;
    logic [REG_DEPTH-1:0] busy_d;

    // Clear is applied first; a same-bit set cannot coincide because the
    // reservation is refused while the bit is busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign src_busy_o  = busy_q[rd1_addr_i] | busy_q[rd2_addr_i];
    assign rsv_free_o  = ~busy_q[rsv_addr_i];
    assign busy_mask_o = busy_q;

endmodule

// File: rtl/regfile_wb_controller.sv
// Write-back arbiter (MEM priority with ALU starvation guard) driving the
// register file write port through one output register, plus a busy scoreboard.
module regfile_wb_controller
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_rsv_valid,
    input  logic [ADDR_WIDTH-1:0] i_rsv_addr,
    output logic                  o_rsv_ready,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    output logic                  o_src_busy,
    input  logic                  i_alu_valid,
    input  logic [ADDR_WIDTH-1:0] i_alu_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_mem_valid,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_mem_ready,
    output logic                  o_rf_write_en,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    output logic [DATA_WIDTH-1:0] o_rf_write_data,
    output logic [REG_DEPTH-1:0]  o_busy_mask
);

    localparam int WaitW = wait_cnt_width(MAX_WAIT);

    logic [WaitW-1:0]      wait_cnt_q;
    logic [WaitW-1:0]      wait_cnt_d;
    logic                  alu_prio;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  grant;
    wb_src_e               src;
    wb_req_t               req;
    logic                  wr_en_d;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] rf_addr_q;
    logic [DATA_WIDTH-1:0] rf_data_q;
    logic                  rsv_free;
    logic                  rsv_set;

    // ALU only beats MEM once it has been starved for MAX_WAIT cycles.
    assign alu_prio  = (wait_cnt_q == WaitW'(MAX_WAIT));
    assign alu_grant = i_alu_valid && (!i_mem_valid || alu_prio);
    assign mem_grant = i_mem_valid && !alu_grant;
    assign grant     = alu_grant || mem_grant;

    always_comb begin
        src        = alu_grant ? WB_ALU : WB_MEM;
        req.addr   = (src == WB_ALU) ? i_alu_addr : i_mem_addr;
        req.data   = (src == WB_ALU) ? i_alu_data : i_mem_data;
        wr_en_d    = grant && (req.addr != '0);
        wait_cnt_d = wait_cnt_q;
        if (!i_alu_valid || alu_grant) begin
            wait_cnt_d = '0;
        end else if (!alu_prio) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wait_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wr_en_q    <= wr_en_d;
            if (grant) begin
                rf_addr_q <= req.addr;
                rf_data_q <= req.data;
            end
        end
    end

    assign rsv_set = i_rsv_valid && rsv_free && (i_rsv_addr != '0);

    reg_scoreboard #(
        .REG_DEPTH  (REG_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .set_en_i    (rsv_set),
        .set_addr_i  (i_rsv_addr),
        .clr_en_i    (wr_en_d),
        .clr_addr_i  (req.addr),
        .rd1_addr_i  (i_rs1_addr),
        .rd2_addr_i  (i_rs2_addr),
        .rsv_addr_i  (i_rsv_addr),
        .src_busy_o  (o_src_busy),
        .rsv_free_o  (rsv_free),
        .busy_mask_o (o_busy_mask)
    );

    assign o_alu_ready     = alu_grant;
    assign o_mem_ready     = mem_grant;
    assign o_rsv_ready     = rsv_free;
    assign o_rf_write_en   = wr_en_q;
    assign o_rf_addr       = rf_addr_q;
    assign o_rf_write_data = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Scoreboard bench for regfile_wb_controller: expected writes are queued at
// grant time and compared when the registered write port presents them.
module tb_regfile_wb_controller;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int RD = 32;
    localparam int MW = 4;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_rsv_valid;
    logic [AW-1:0] i_rsv_addr;
    logic          o_rsv_ready;
    logic [AW-1:0] i_rs1_addr;
    logic [AW-1:0] i_rs2_addr;
    logic          o_src_busy;
    logic          i_alu_valid;
    logic [AW-1:0] i_alu_addr;
    logic [DW-1:0] i_alu_data;
    logic          o_alu_ready;
    logic          i_mem_valid;
    logic [AW-1:0] i_mem_addr;
    logic [DW-1:0] i_mem_data;
    logic          o_mem_ready;
    logic          o_rf_write_en;
    logic [AW-1:0] o_rf_addr;
    logic [DW-1:0] o_rf_write_data;
    logic [RD-1:0] o_busy_mask;

    regfile_wb_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .REG_DEPTH  (RD),
        .MAX_WAIT   (MW)
    ) dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_rsv_valid     (i_rsv_valid),
        .i_rsv_addr      (i_rsv_addr),
        .o_rsv_ready     (o_rsv_ready),
        .i_rs1_addr      (i_rs1_addr),
        .i_rs2_addr      (i_rs2_addr),
        .o_src_busy      (o_src_busy),
        .i_alu_valid     (i_alu_valid),
        .i_alu_addr      (i_alu_addr),
        .i_alu_data      (i_alu_data),
        .o_alu_ready     (o_alu_ready),
        .i_mem_valid     (i_mem_valid),
        .i_mem_addr      (i_mem_addr),
        .i_mem_data      (i_mem_data),
        .o_mem_ready     (o_mem_ready),
        .o_rf_write_en   (o_rf_write_en),
        .o_rf_addr       (o_rf_addr),
        .o_rf_write_data (o_rf_write_data),
        .o_busy_mask     (o_busy_mask)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [RD-1:0] m_busy;
    int            m_wait;
    bit            m_alu_rdy;
    bit            m_mem_rdy;
    int            mem_grants;
    int            alu_grants;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        i_rsv_valid = 1'b0;
        i_rsv_addr  = '0;
        i_rs1_addr  = '0;
        i_rs2_addr  = '0;
        i_alu_valid = 1'b0;
        i_alu_addr  = '0;
        i_alu_data  = '0;
        i_mem_valid = 1'b0;
        i_mem_addr  = '0;
        i_mem_data  = '0;
    endtask

    task automatic model_reset();
        m_busy    = '0;
        m_wait    = 0;
        m_alu_rdy = 1'b0;
        m_mem_rdy = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic tick();
        bit            prio;
        bit            rsv_ok;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        wr_t           w;
        #1;
        prio      = (m_wait == MW);
        m_alu_rdy = i_alu_valid && (!i_mem_valid || prio);
        m_mem_rdy = i_mem_valid && !m_alu_rdy;
        rsv_ok    = !m_busy[i_rsv_addr];
        check_val("alu_ready", o_alu_ready, m_alu_rdy);
        check_val("mem_ready", o_mem_ready, m_mem_rdy);
        check_val("rsv_ready", o_rsv_ready, rsv_ok);
        check_val("src_busy", o_src_busy, m_busy[i_rs1_addr] | m_busy[i_rs2_addr]);
        if (m_alu_rdy) alu_grants++;
        if (m_mem_rdy) mem_grants++;
        if (m_alu_rdy || m_mem_rdy) begin
            a = m_alu_rdy ? i_alu_addr : i_mem_addr;
            d = m_alu_rdy ? i_alu_data : i_mem_data;
            if (a != '0) begin
                w.addr = a;
                w.data = d;
                exp_q.push_back(w);
                m_busy[a] = 1'b0;
            end
        end
        if (i_rsv_valid && rsv_ok && i_rsv_addr != '0) m_busy[i_rsv_addr] = 1'b1;
        if (!i_alu_valid || m_alu_rdy) m_wait = 0;
        else if (m_wait < MW) m_wait++;
        @(posedge i_clk);
        #1;
        check_val("rf_write_en", o_rf_write_en, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            if (o_rf_write_en) begin
                check_val("rf_addr", o_rf_addr, w.addr);
                check_val("rf_write_data", o_rf_write_data, w.data);
            end
        end
        check_val("busy_mask", o_busy_mask, m_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        i_arst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_arst = 1'b0;
        #1;
        check_val("reset_wen", o_rf_write_en, 1'b0);
        check_val("reset_addr", o_rf_addr, '0);
        check_val("reset_data", o_rf_write_data, '0);
        check_val("reset_mask", o_busy_mask, '0);
        check_val("reset_alu_ready", o_alu_ready, 1'b0);
        check_val("reset_mem_ready", o_mem_ready, 1'b0);

        // Reserve x5, retry reservation, then RAW lookup on rs1.
        i_rsv_valid = 1'b1; i_rsv_addr = 5'd5;
        tick();
        check_val("x5_busy", o_busy_mask[5], 1'b1);
        tick();
        i_rsv_valid = 1'b0; i_rs1_addr = 5'd5;
        tick();

        // Load write-back to x5 clears the hazard.
        i_mem_valid = 1'b1; i_mem_addr = 5'd5; i_mem_data = 64'hDEAD;
        tick();
        check_val("x5_wb_addr", o_rf_addr, 5'd5);
        check_val("x5_wb_data", o_rf_write_data, 64'hDEAD);
        i_mem_valid = 1'b0;
        tick();
        check_val("x5_src_free", o_src_busy, 1'b0);

        // Both requesters valid: starvation guard hands ALU the 5th slot.
        i_rs1_addr = '0;
        i_alu_valid = 1'b1; i_alu_addr = 5'd3; i_alu_data = 64'hA3;
        i_mem_valid = 1'b1; i_mem_addr = 5'd4; i_mem_data = 64'hB4;
        mem_grants = 0; alu_grants = 0;
        repeat (4) tick();
        check_val("starve_mem_grants", mem_grants, 4);
        check_val("starve_alu_grants", alu_grants, 0);
        tick();
        check_val("starve_alu_5th", alu_grants, 1);
        i_alu_valid = 1'b0;
        tick();
        check_val("mem_resumes", mem_grants, 5);
        i_mem_valid = 1'b0;

        // ALU write to x0: handshake completes, no register write.
        i_alu_valid = 1'b1; i_alu_addr = '0; i_alu_data = 64'h1234;
        tick();
        check_val("x0_no_write", o_rf_write_en, 1'b0);
        i_alu_valid = 1'b0;

        // Reserve x7 in the same cycle x9 is cleared.
        i_rsv_valid = 1'b1; i_rsv_addr = 5'd9;
        tick();
        i_rsv_addr = 5'd7;
        i_mem_valid = 1'b1; i_mem_addr = 5'd9; i_mem_data = 64'h99;
        tick();
        check_val("set_clr_x7", o_busy_mask[7], 1'b1);
        check_val("set_clr_x9", o_busy_mask[9], 1'b0);
        idle();

        // Asynchronous reset while a write is on the port and another is granted.
        i_rsv_valid = 1'b1; i_rsv_addr = 5'd5;
        tick();
        i_rsv_addr = 5'd6;
        tick();
        i_rsv_valid = 1'b0;
        i_alu_valid = 1'b1; i_alu_addr = 5'd3; i_alu_data = 64'h33;
        i_mem_valid = 1'b1; i_mem_addr = 5'd6; i_mem_data = 64'h66;
        tick();
        check_val("pre_reset_wen", o_rf_write_en, 1'b1);
        i_mem_addr = 5'd5; i_mem_data = 64'h55;
        #2;
        i_arst = 1'b1;
        #1;
        check_val("arst_wen", o_rf_write_en, 1'b0);
        check_val("arst_addr", o_rf_addr, '0);
        check_val("arst_mask", o_busy_mask, '0);
        check_val("arst_mem_ready", o_mem_ready, 1'b1);
        @(negedge i_clk);
        i_arst = 1'b0;
        model_reset();
        tick();
        idle();
        i_rsv_valid = 1'b1; i_rsv_addr = 5'd5;
        tick();
        check_val("post_reset_rsv_x5", o_busy_mask[5], 1'b1);
        idle();

        // Random traffic honouring hold-until-ready.
        for (int i = 0; i < 80; i++) begin
            if (!i_alu_valid || m_alu_rdy) begin
                i_alu_valid = 1'($urandom_range(0, 1));
                i_alu_addr  = AW'($urandom_range(0, 7));
                i_alu_data  = {$urandom, $urandom};
            end
            if (!i_mem_valid || m_mem_rdy) begin
                i_mem_valid = 1'($urandom_range(0, 1));
                i_mem_addr  = AW'($urandom_range(0, 7));
                i_mem_data  = {$urandom, $urandom};
            end
            i_rsv_valid = 1'($urandom_range(0, 1));
            i_rsv_addr  = AW'($urandom_range(0, 7));
            i_rs1_addr  = AW'($urandom_range(0, 7));
            i_rs2_addr  = AW'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_controller.md
Name: regfile_wb_controller

Overview:
Write-back controller in front of the single write port of the integer register file. It arbitrates between two write-back requesters (ALU and memory/load unit) over valid/ready handshakes and drives the register file write port from a registered output stage. It also keeps a per-register busy scoreboard so the issue stage can stall on RAW and WAW hazards.

Parameters:
DATA_WIDTH, 64, width of write-back data
ADDR_WIDTH, 5, register address width
REG_DEPTH, 32, number of architectural registers
MAX_WAIT, 4, cycles the ALU requester may be starved before it takes priority

Ports:
i_clk  input  1  clock
i_arst  input  1  reset, asynchronous, active-high
i_rsv_valid  input  1  issue stage requests reservation of a destination register
i_rsv_addr  input  ADDR_WIDTH  destination register to reserve
o_rsv_ready  output  1  reservation accepted (destination not busy)
i_rs1_addr  input  ADDR_WIDTH  source 1 of the instruction in issue
i_rs2_addr  input  ADDR_WIDTH  source 2 of the instruction in issue
o_src_busy  output  1  either source has a pending write (RAW stall)
i_alu_valid  input  1  ALU write-back request
i_alu_addr  input  ADDR_WIDTH  ALU destination
i_alu_data  input  DATA_WIDTH  ALU result
o_alu_ready  output  1  ALU request granted this cycle
i_mem_valid  input  1  load write-back request
i_mem_addr  input  ADDR_WIDTH  load destination
i_mem_data  input  DATA_WIDTH  load data
o_mem_ready  output  1  load request granted this cycle
o_rf_write_en  output  1  register file write enable
o_rf_addr  output  ADDR_WIDTH  register file write address
o_rf_write_data  output  DATA_WIDTH  register file write data
o_busy_mask  output  REG_DEPTH  scoreboard bits, debug/visibility

Behaviour:
- Handshake: a transfer occurs when valid && ready on a cycle. Requesters hold valid, addr and data stable until ready. ready is combinational from valid, the arbiter state and the wait counter. At most one grant per cycle.
- Arbitration: the default priority is MEM.
  - wait_cnt increments in each cycle where i_alu_valid=1 and the ALU is not granted. It saturates at MAX_WAIT.
  - When wait_cnt == MAX_WAIT, the ALU wins over MEM.
  - wait_cnt clears to 0 on an ALU grant or when i_alu_valid=0.
  - Each grant is combinational in cycle N. o_rf_write_en/o_rf_addr/o_rf_write_data are registered and present the write in cycle N+1, so latency is 1 cycle. With no grant, o_rf_write_en=0 in N+1. Addr/data hold their last value.
- Address 0: the grant is still given (handshake completes). o_rf_write_en stays 0 and the scoreboard is untouched.
- Scoreboard busy[REG_DEPTH]:
  - Set: busy[i_rsv_addr] sets at the edge where i_rsv_valid && o_rsv_ready && i_rsv_addr != 0.
  - Clear: busy[addr] of the granted write clears at the grant edge. From the next cycle the write is on the register file port, and the register file's write-to-read bypass supplies the value.
  - Clearing a non-busy bit is a no-op; unreserved writes are legal.
  - A set and a clear in the same cycle on different bits both take effect. The same bit cannot occur for both, because o_rsv_ready=0 while busy.
  - busy[0] is constant 0.
- o_rsv_ready = !busy[i_rsv_addr], independent of i_rsv_valid.
- o_src_busy = busy[i_rs1_addr] | busy[i_rs2_addr].
- Reset (any time, including mid-transfer):
  - o_rf_write_en=0, o_rf_addr=0, o_rf_write_data=0.
  - busy all 0, wait_cnt=0.
  - An in-flight granted write is discarded.
  - Ready outputs follow the reset state combinationally.

Decomposition:
- Package regfile_ctrl_pkg:
  - typedef wb_req_t {addr, data}
  - enum wb_src_e {WB_ALU, WB_MEM}
  - localparam for wait counter width, $clog2(MAX_WAIT+1)
- Sub-module reg_scoreboard (REG_DEPTH, ADDR_WIDTH) holds the busy bits:
  - set port, clear port, two read-address lookups, the reservation lookup, and the mask output.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset, then reserve x5 (i_rsv_valid=1, addr 5) -> busy[5]=1 next cycle. A second reserve of x5 sees o_rsv_ready=0. Setting rs1=5 gives o_src_busy=1.
- MEM valid addr 5 data 0xDEAD -> o_mem_ready=1 in cycle N. In N+1: o_rf_write_en=1, o_rf_addr=5, o_rf_write_data=0xDEAD, busy[5]=0, o_src_busy=0.
- ALU and MEM both valid continuously (addrs 3, 4) -> MEM granted 4 cycles, ALU granted on the 5th cycle (wait_cnt=MAX_WAIT), then MEM resumes.
- ALU write to x0, data 0x1234 -> o_alu_ready=1; o_rf_write_en stays 0 next cycle; busy mask unchanged.
- Reserve x7 in the same cycle as the grant clearing x9 (x9 previously reserved) -> next cycle busy[7]=1, busy[9]=0.
- Assert i_arst asynchronously mid-grant with busy[5]=1 -> o_rf_write_en=0 immediately, busy mask 0, wait_cnt 0. After release, reserve x5 is accepted.
